// File: rtl/ifu_pkg.sv
// Shared types and sizes for the instruction fetch unit and its skid buffer.
package ifu_pkg;

  localparam int IFU_BUF_DEPTH = 2;
  localparam int IFU_ADDR_W    = 32;
  localparam int IFU_DATA_W    = 32;
  localparam int IFU_ENTRY_W   = IFU_ADDR_W + IFU_DATA_W;
  localparam int IFU_CNT_W     = $clog2(IFU_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_DATA_W-1:0] instr;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_skid_buffer.sv
// Two-entry FIFO holding {pc, instruction} pairs between the ROM and decode.
// A flush empties it and overrides any push or pop in the same cycle.
module ifu_skid_buffer
  import ifu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  ifu_entry_t           data_i,
  output logic [IFU_CNT_W-1:0] count_o,
  output ifu_entry_t           head_o
);

  ifu_entry_t           mem_q [IFU_BUF_DEPTH];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [IFU_CNT_W-1:0] count_q, count_d;
  logic                 wr_en, rd_en;

  always_comb begin
    rd_en    = pop_i && !flush_i && (count_q != '0);
    // A push into a full buffer is only legal when the head leaves this cycle.
    wr_en    = push_i && !flush_i &&
               ((count_q < IFU_CNT_W'(IFU_BUF_DEPTH)) || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + IFU_CNT_W'(wr_en) - IFU_CNT_W'(rd_en);
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ~wr_ptr_q;
      if (rd_en) rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < IFU_BUF_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (wr_en && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= data_i;
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the PC, addresses the async-read ROM, and feeds
// decode through a two-entry skid buffer with flush/redirect and halt.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [IFU_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [IFU_ADDR_W-1:0] PC_LIMIT = 32'd32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [IFU_ADDR_W-1:0] imem_pc,
  input  logic [IFU_DATA_W-1:0] imem_instruction,
  input  logic                  redirect_valid,
  input  logic [IFU_ADDR_W-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [IFU_DATA_W-1:0] inst_out,
  output logic [IFU_ADDR_W-1:0] inst_pc,
  output logic                  halted
);

  ifu_state_t            state_q, state_d;
  logic [IFU_ADDR_W-1:0] pc_q, pc_d;
  logic [IFU_CNT_W-1:0]  count;
  logic [IFU_CNT_W-1:0]  count_after_pop;
  ifu_entry_t            head;
  ifu_entry_t            push_entry;
  logic                  push, pop, flush, in_window;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    push            = 1'b0;
    flush           = 1'b0;
    pop             = inst_valid && inst_ready;
    in_window       = pc_q < PC_LIMIT;
    count_after_pop = count - IFU_CNT_W'(pop);
    push_entry      = '{pc: pc_q, instr: imem_instruction};

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = {redirect_pc[IFU_ADDR_W-1:2], 2'b00};
        end else begin
          push = in_window && ((count < IFU_CNT_W'(IFU_BUF_DEPTH)) || pop);
          if (push) pc_d = pc_q + 32'd4;
          if (!in_window && (count_after_pop == '0)) state_d = HALT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = {redirect_pc[IFU_ADDR_W-1:2], 2'b00};
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Flush outranks pop inside the buffer, so a handshake in a redirect cycle is void.
  ifu_skid_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (push_entry),
    .count_o (count),
    .head_o  (head)
  );

  assign imem_pc    = pc_q;
  assign inst_valid = (count != '0);
  assign inst_out   = head.instr;
  assign inst_pc    = head.pc;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for stream,
// halt and redirect behaviour, then hand-written backpressure/reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        halted;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_LIMIT (32'd32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_out         (inst_out),
    .inst_pc          (inst_pc),
    .halted           (halted)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'd16) return 32'h0004_1800 + {14'd0, a[3:2], 16'd0};
    return 32'h0;
  endfunction

  assign imem_instruction = rom(imem_pc);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic        e_halt;
    logic [31:0] e_imem;
  } vec_t;

  vec_t vecs [22];

  initial begin
    // {start, ready, redirect_valid, redirect_pc, exp valid, exp out, exp pc, exp halted, exp imem_pc}
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00041800, 32'h00, 1'b0, 32'h04};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00051800, 32'h04, 1'b0, 32'h08};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00061800, 32'h08, 1'b0, 32'h0C};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00071800, 32'h0C, 1'b0, 32'h10};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0,        32'h10, 1'b0, 32'h14};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0,        32'h14, 1'b0, 32'h18};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0,        32'h18, 1'b0, 32'h1C};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0,        32'h1C, 1'b0, 32'h20};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b1, 32'h20};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0,        32'h00, 1'b1, 32'h20};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b0, 32'h04};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0E, 1'b1, 32'h00051800, 32'h04, 1'b0, 32'h08};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b0, 32'h0C};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00071800, 32'h0C, 1'b0, 32'h10};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00071800, 32'h0C, 1'b0, 32'h14};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00071800, 32'h0C, 1'b0, 32'h14};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h0,        32'h10, 1'b0, 32'h18};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b0, 32'h40};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b1, 32'h40};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,        32'h00, 1'b1, 32'h40};

    rst_n          = 1'b0;
    start          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);

    chk("reset_valid",  {31'd0, inst_valid}, 32'd0);
    chk("reset_out",    inst_out, 32'h0);
    chk("reset_pc",     inst_pc, 32'h0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_imem",   imem_pc, 32'h0);
    rst_n = 1'b1;

    // Each entry: check outputs of the current cycle, then drive its inputs.
    for (int i = 0; i < 22; i++) begin
      $display("vec %0d: valid=%b out=%08h pc=%08h halted=%b imem_pc=%08h",
               i, inst_valid, inst_out, inst_pc, halted, imem_pc);
      chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halt});
      chk($sformatf("vec%0d_imem_pc", i), imem_pc, vecs[i].e_imem);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_inst_out", i), inst_out, vecs[i].e_out);
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
      end
      start          = vecs[i].start;
      inst_ready     = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
    end

    // Backpressure from the first valid word, then ordered drain.
    rst_n          = 1'b0;
    start          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    $display("bp first: valid=%b out=%08h pc=%08h imem_pc=%08h", inst_valid, inst_out, inst_pc, imem_pc);
    chk("bp_first_valid", {31'd0, inst_valid}, 32'd1);
    chk("bp_first_out",   inst_out, 32'h0004_1800);
    chk("bp_first_pc",    inst_pc, 32'h0);
    chk("bp_first_imem",  imem_pc, 32'h04);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      $display("bp hold %0d: valid=%b out=%08h imem_pc=%08h", i, inst_valid, inst_out, imem_pc);
      chk($sformatf("bp_hold%0d_valid", i), {31'd0, inst_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_out", i), inst_out, 32'h0004_1800);
      chk($sformatf("bp_hold%0d_imem", i), imem_pc, 32'h08);
      if (i == 4) inst_ready = 1'b1;
      @(negedge clk);
    end
    for (int k = 1; k <= 3; k++) begin
      $display("bp drain %0d: valid=%b out=%08h pc=%08h", k, inst_valid, inst_out, inst_pc);
      chk($sformatf("bp_drain%0d_valid", k), {31'd0, inst_valid}, 32'd1);
      chk($sformatf("bp_drain%0d_pc", k), inst_pc, 32'(4 * k));
      chk($sformatf("bp_drain%0d_out", k), inst_out, rom(32'(4 * k)));
      if (k == 3) inst_ready = 1'b0;
      @(negedge clk);
    end
    $display("pre-reset: valid=%b out=%08h imem_pc=%08h", inst_valid, inst_out, imem_pc);
    chk("full_out",  inst_out, 32'h0007_1800);
    chk("full_imem", imem_pc, 32'h14);

    // Asynchronous reset while two entries are buffered.
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%b out=%08h pc=%08h halted=%b imem_pc=%08h",
             inst_valid, inst_out, inst_pc, halted, imem_pc);
    chk("arst_valid",  {31'd0, inst_valid}, 32'd0);
    chk("arst_out",    inst_out, 32'h0);
    chk("arst_pc",     inst_pc, 32'h0);
    chk("arst_imem",   imem_pc, 32'h0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      $display("idle %0d: valid=%b halted=%b imem_pc=%08h", i, inst_valid, halted, imem_pc);
      chk($sformatf("idle%0d_valid", i), {31'd0, inst_valid}, 32'd0);
      chk($sformatf("idle%0d_imem", i), imem_pc, 32'h0);
      chk($sformatf("idle%0d_halted", i), {31'd0, halted}, 32'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
